// File: rtl/instruction_fetch_if.sv
// IF-stage bus bundle: fetch address/data to instructionMem, decode handshake,
// redirect request and the IF/ID pipeline register outputs.
interface instruction_fetch_if;
   logic [31:0] pc;
   logic [31:0] instr_in;
   logic        id_ready;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_id_valid;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_pc4;
   logic        fetch_stop;
   logic        fetch_fault;
   logic [31:0] fetch_count;

   modport master (
      output pc, if_id_valid, if_id_instr, if_id_pc, if_id_pc4,
             fetch_stop, fetch_fault, fetch_count,
      input  instr_in, id_ready, redirect_valid, redirect_pc
   );

   modport slave (
      input  pc, if_id_valid, if_id_instr, if_id_pc, if_id_pc4,
             fetch_stop, fetch_fault, fetch_count,
      output instr_in, id_ready, redirect_valid, redirect_pc
   );
endinterface

// File: rtl/instruction_fetch.sv
// IF stage: owns the PC, fetches from instructionMem and fills the IF/ID register.
// Optional macro FETCH_ALIGN_CHECK_EN traps misaligned redirects into a sticky fault.
module instruction_fetch #(
   parameter logic [31:0] RESET_PC  = 32'h0,
   parameter int unsigned MEM_BYTES = 512
) (
   input logic           clk,
   input logic           rst,
   instruction_fetch_if.master bus
);

   typedef enum logic [1:0] {RUN, STOP, FAULT} state_t;

   state_t      state;
   logic [31:0] pc_q;
   logic        valid_q;
   logic [31:0] instr_q;
   logic [31:0] ipc_q;
   logic [31:0] ipc4_q;
   logic        stop_q;
   logic [31:0] count_q;
   logic [31:0] pc_next4;
   logic [32:0] last_byte;
   logic        in_range;
   logic        misaligned;

   // 33-bit sum so a PC near 2^32 cannot wrap into a false in-range hit
   assign last_byte = {1'b0, pc_q} + 33'd3;
   assign in_range  = last_byte < 33'(MEM_BYTES);
   assign pc_next4  = pc_q + 32'd4;

`ifdef FETCH_ALIGN_CHECK_EN
   logic fault_q;
   assign misaligned      = bus.redirect_pc[1:0] != 2'b00;
   assign bus.fetch_fault = fault_q;
`else
   assign misaligned      = 1'b0;
   assign bus.fetch_fault = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= RUN;
         pc_q    <= RESET_PC;
         valid_q <= 1'b0;
         instr_q <= '0;
         ipc_q   <= '0;
         ipc4_q  <= '0;
         stop_q  <= 1'b0;
         count_q <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
         fault_q <= 1'b0;
`endif
      end else if (state != FAULT) begin
         if (bus.redirect_valid) begin
            if (misaligned) begin
`ifdef FETCH_ALIGN_CHECK_EN
               fault_q <= 1'b1;
`endif
               state   <= FAULT;
               valid_q <= 1'b0;
            end else begin
               state   <= RUN;
               pc_q    <= bus.redirect_pc;
               valid_q <= 1'b0;
               stop_q  <= 1'b0;
            end
         end else if (bus.id_ready && state == RUN) begin
            if (in_range) begin
               valid_q <= 1'b1;
               instr_q <= bus.instr_in;
               ipc_q   <= pc_q;
               ipc4_q  <= pc_next4;
               pc_q    <= pc_next4;
               count_q <= count_q + 32'd1;
            end else begin
               state   <= STOP;
               valid_q <= 1'b0;
               stop_q  <= 1'b1;
            end
         end
      end
   end

   assign bus.pc          = pc_q;
   assign bus.if_id_valid = valid_q;
   assign bus.if_id_instr = instr_q;
   assign bus.if_id_pc    = ipc_q;
   assign bus.if_id_pc4   = ipc4_q;
   assign bus.fetch_stop  = stop_q;
   assign bus.fetch_count = count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a synthetic instruction memory.
// Expectations follow FETCH_ALIGN_CHECK_EN when the macro is defined.
module tb_instruction_fetch;

   logic clk;
   logic rst;
   int unsigned n_checks;
   int unsigned n_fail;

   instruction_fetch_if bus ();

   instruction_fetch #(
      .RESET_PC  (32'h0),
      .MEM_BYTES (512)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: two fixed words, everything else {pc[15:0], ~pc[15:0]}
   always_comb begin
      if (bus.pc == 32'h0)      bus.instr_in = 32'h2402_0006;
      else if (bus.pc == 32'h4) bus.instr_in = 32'h2401_0005;
      else                      bus.instr_in = {bus.pc[15:0], ~bus.pc[15:0]};
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_ifid(input string tag, input logic v, input logic [31:0] ins,
                             input logic [31:0] ipc, input logic [31:0] npc);
      check({tag, "_valid"}, 32'(bus.if_id_valid), 32'(v));
      check({tag, "_instr"}, bus.if_id_instr, ins);
      check({tag, "_ifpc"},  bus.if_id_pc, ipc);
      check({tag, "_pc4"},   bus.if_id_pc4, ipc + 32'd4);
      check({tag, "_pc"},    bus.pc, npc);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst = 1'b1;
      bus.id_ready       = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      #12;
      check("rst_pc",    bus.pc, 32'h0);
      check("rst_valid", 32'(bus.if_id_valid), 32'h0);
      check("rst_instr", bus.if_id_instr, 32'h0);
      check("rst_count", bus.fetch_count, 32'h0);
      check("rst_stop",  32'(bus.fetch_stop), 32'h0);
      check("rst_fault", 32'(bus.fetch_fault), 32'h0);
      rst = 1'b0;

      // Sequential fetch
      step();
      check_ifid("seq1", 1'b1, 32'h2402_0006, 32'h0, 32'h4);
      check("seq1_count", bus.fetch_count, 32'd1);
      step();
      check_ifid("seq2", 1'b1, 32'h2401_0005, 32'h4, 32'h8);
      check("seq2_count", bus.fetch_count, 32'd2);

      // Stall for three cycles, then release
      bus.id_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check_ifid("stall", 1'b1, 32'h2401_0005, 32'h4, 32'h8);
         check("stall_count", bus.fetch_count, 32'd2);
      end
      bus.id_ready = 1'b1;
      step();
      check_ifid("release", 1'b1, 32'h0008_FFF7, 32'h8, 32'hC);
      check("release_count", bus.fetch_count, 32'd3);

      // Redirect wins over stall
      bus.id_ready       = 1'b0;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h10;
      step();
      check("redir_pc",    bus.pc, 32'h10);
      check("redir_valid", 32'(bus.if_id_valid), 32'h0);
      check("redir_count", bus.fetch_count, 32'd3);
      bus.redirect_valid = 1'b0;
      bus.id_ready       = 1'b1;
      step();
      check_ifid("after_redir", 1'b1, 32'h0010_FFEF, 32'h10, 32'h14);
      check("after_redir_count", bus.fetch_count, 32'd4);

      // End of memory
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h1F8;
      step();
      bus.redirect_valid = 1'b0;
      check("eom_pc", bus.pc, 32'h1F8);
      step();
      check_ifid("eom_1f8", 1'b1, 32'h01F8_FE07, 32'h1F8, 32'h1FC);
      step();
      check_ifid("eom_1fc", 1'b1, 32'h01FC_FE03, 32'h1FC, 32'h200);
      check("eom_1fc_count", bus.fetch_count, 32'd6);
      check("eom_1fc_stop",  32'(bus.fetch_stop), 32'h0);
      step();
      check("eom_stop",  32'(bus.fetch_stop), 32'h1);
      check("eom_valid", 32'(bus.if_id_valid), 32'h0);
      check("eom_pc2",   bus.pc, 32'h200);
      check("eom_count", bus.fetch_count, 32'd6);
      step();
      check("eom_hold_stop", 32'(bus.fetch_stop), 32'h1);
      check("eom_hold_pc",   bus.pc, 32'h200);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h0;
      step();
      bus.redirect_valid = 1'b0;
      check("resume_stop", 32'(bus.fetch_stop), 32'h0);
      check("resume_pc",   bus.pc, 32'h0);
      step();
      check_ifid("resume", 1'b1, 32'h2402_0006, 32'h0, 32'h4);
      check("resume_count", bus.fetch_count, 32'd7);

      // PC at top of address space: pc+3 must not wrap into range
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'hFFFF_FFFC;
      step();
      bus.redirect_valid = 1'b0;
      check("wrap_pc", bus.pc, 32'hFFFF_FFFC);
      step();
      check("wrap_stop",  32'(bus.fetch_stop), 32'h1);
      check("wrap_valid", 32'(bus.if_id_valid), 32'h0);
      check("wrap_pc2",   bus.pc, 32'hFFFF_FFFC);
      check("wrap_count", bus.fetch_count, 32'd7);

      // Asynchronous reset between edges
      #3;
      rst = 1'b1;
      #1;
      check("arst_pc",    bus.pc, 32'h0);
      check("arst_valid", 32'(bus.if_id_valid), 32'h0);
      check("arst_count", bus.fetch_count, 32'h0);
      check("arst_stop",  32'(bus.fetch_stop), 32'h0);
      rst = 1'b0;
      step();
      check_ifid("post_rst", 1'b1, 32'h2402_0006, 32'h0, 32'h4);
      check("post_rst_count", bus.fetch_count, 32'd1);

      // Misaligned redirect
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h12;
      step();
      check("mis_valid", 32'(bus.if_id_valid), 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
      check("mis_pc",    bus.pc, 32'h4);
      check("mis_fault", 32'(bus.fetch_fault), 32'h1);
      bus.redirect_pc = 32'h20;
      step();
      bus.redirect_valid = 1'b0;
      check("mis_ignored_pc", bus.pc, 32'h4);
      check("mis_fault2",     32'(bus.fetch_fault), 32'h1);
      step();
      check("mis_halt_pc",    bus.pc, 32'h4);
      check("mis_halt_count", bus.fetch_count, 32'd1);
`else
      check("mis_pc",    bus.pc, 32'h12);
      check("mis_fault", 32'(bus.fetch_fault), 32'h0);
      bus.redirect_valid = 1'b0;
      step();
      check_ifid("mis_fetch", 1'b1, 32'h0012_FFED, 32'h12, 32'h16);
      check("mis_count", bus.fetch_count, 32'd2);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
